// File: rtl/dma_utils_pkg.sv
// Shared DMA types: streamer request/response, write command queue entry and AXI burst constants.
package dma_utils_pkg;

    localparam int unsigned DMA_DATA_WIDTH = 32;
    localparam int unsigned DMA_ADDR_WIDTH = 32;
    localparam int unsigned DMA_STRB_WIDTH = DMA_DATA_WIDTH / 8;
    localparam int unsigned AXI_ID_WIDTH   = 4;

    typedef logic [1:0] axi_burst_t;

    localparam axi_burst_t BURST_FIXED = 2'b00;
    localparam axi_burst_t BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_OKAY    = 2'b00;

    typedef struct packed {
        logic                      valid;
        logic [DMA_ADDR_WIDTH-1:0] addr;
        logic [7:0]                alen;
        logic [2:0]                size;
        logic [DMA_STRB_WIDTH-1:0] strb;
        axi_burst_t                mode;
    } s_dma_axi_req_t;

    typedef struct packed {
        logic ready;
    } s_dma_axi_resp_t;

    typedef struct packed {
        logic [7:0]                alen;
        logic [DMA_STRB_WIDTH-1:0] strb;
    } s_wr_cmd_t;

endpackage

// File: rtl/dma_wr_cmdq.sv
// Synchronous FIFO of write commands {alen,strb}; one entry per accepted burst awaiting its W beats.
module dma_wr_cmdq
    import dma_utils_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  s_wr_cmd_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output s_wr_cmd_t head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    s_wr_cmd_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dma_axi_wr_chan.sv
// AXI4 write-channel master: one AW plus alen+1 W beats per accepted streamer burst, B tracking.
// Optional macro DMA_WR_BRESP_CHK_EN enables sticky BRESP error detection and accept blocking.
module dma_axi_wr_chan
    import dma_utils_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned AXI_ID          = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dma_abort_i,
    input  s_dma_axi_req_t            dma_axi_req_i,
    output s_dma_axi_resp_t           dma_axi_resp_o,
    input  logic [DMA_DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                      fifo_empty_i,
    output logic                      fifo_rd_o,
    output logic                      awvalid_o,
    input  logic                      awready_i,
    output logic [DMA_ADDR_WIDTH-1:0] awaddr_o,
    output logic [7:0]                awlen_o,
    output logic [2:0]                awsize_o,
    output axi_burst_t                awburst_o,
    output logic [AXI_ID_WIDTH-1:0]   awid_o,
    output logic                      wvalid_o,
    input  logic                      wready_i,
    output logic [DMA_DATA_WIDTH-1:0] wdata_o,
    output logic [DMA_STRB_WIDTH-1:0] wstrb_o,
    output logic                      wlast_o,
    input  logic                      bvalid_i,
    output logic                      bready_o,
    input  logic [1:0]                bresp_i,
    output logic                      wr_idle_o,
    output logic                      wr_error_o
);

    localparam int unsigned      OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    logic                      awvalid_q, awvalid_d;
    logic [DMA_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]                awlen_q, awlen_d;
    logic [2:0]                awsize_q, awsize_d;
    axi_burst_t                awburst_q, awburst_d;
    logic [7:0]                beat_q, beat_d;
    logic [OUT_W-1:0]          outstanding_q, outstanding_d;
    logic                      error_q, error_d;

    logic      aw_free;
    logic      accept;
    logic      err_block;
    logic      w_hs;
    logic      b_hs;
    logic      cmdq_full;
    logic      cmdq_empty;
    logic      cmdq_pop;
    s_wr_cmd_t cmdq_push_data;
    s_wr_cmd_t cmdq_head;

    assign aw_free = ~awvalid_q | awready_i;

    // Reset gating keeps ready low while the slave side is also being reset.
    assign accept = dma_axi_req_i.valid & ~dma_abort_i & aw_free & ~cmdq_full &
                    (outstanding_q < OUT_MAX) & ~err_block & ~rst;

    assign dma_axi_resp_o.ready = accept;

    assign cmdq_push_data.alen = dma_axi_req_i.alen;
    assign cmdq_push_data.strb = dma_axi_req_i.strb;

    dma_wr_cmdq #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_cmdq (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (cmdq_push_data),
        .pop       (cmdq_pop),
        .full      (cmdq_full),
        .empty     (cmdq_empty),
        .head      (cmdq_head)
    );

    assign wvalid_o  = ~cmdq_empty & ~fifo_empty_i;
    assign wdata_o   = fifo_rd_data_i;
    assign wstrb_o   = cmdq_head.strb;
    assign wlast_o   = (beat_q == cmdq_head.alen);
    assign w_hs      = wvalid_o & wready_i;
    assign fifo_rd_o = w_hs;
    assign cmdq_pop  = w_hs & wlast_o;

    assign bready_o = 1'b1;
    assign b_hs     = bvalid_i & bready_o;

`ifdef DMA_WR_BRESP_CHK_EN
    assign err_block = error_q;
    assign error_d   = error_q | (b_hs & (bresp_i != AXI_OKAY));
`else
    logic unused_bresp;
    assign unused_bresp = ^bresp_i;
    assign err_block    = 1'b0;
    assign error_d      = 1'b0;
`endif

    always_comb begin
        awvalid_d     = awvalid_q;
        awaddr_d      = awaddr_q;
        awlen_d       = awlen_q;
        awsize_d      = awsize_q;
        awburst_d     = awburst_q;
        beat_d        = beat_q;
        outstanding_d = outstanding_q;

        // A new accept may overwrite the AW register in the same cycle the old one handshakes.
        if (accept) begin
            awvalid_d = 1'b1;
            awaddr_d  = dma_axi_req_i.addr;
            awlen_d   = dma_axi_req_i.alen;
            awsize_d  = dma_axi_req_i.size;
            awburst_d = dma_axi_req_i.mode;
        end else if (awready_i) begin
            awvalid_d = 1'b0;
        end

        if (w_hs) begin
            beat_d = wlast_o ? 8'd0 : beat_q + 8'd1;
        end

        case ({accept, b_hs & (outstanding_q != '0)})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            awvalid_q     <= 1'b0;
            awaddr_q      <= '0;
            awlen_q       <= '0;
            awsize_q      <= '0;
            awburst_q     <= BURST_FIXED;
            beat_q        <= '0;
            outstanding_q <= '0;
            error_q       <= 1'b0;
        end else begin
            awvalid_q     <= awvalid_d;
            awaddr_q      <= awaddr_d;
            awlen_q       <= awlen_d;
            awsize_q      <= awsize_d;
            awburst_q     <= awburst_d;
            beat_q        <= beat_d;
            outstanding_q <= outstanding_d;
            error_q       <= error_d;
        end
    end

    assign awvalid_o  = awvalid_q;
    assign awaddr_o   = awaddr_q;
    assign awlen_o    = awlen_q;
    assign awsize_o   = awsize_q;
    assign awburst_o  = awburst_q;
    assign awid_o     = AXI_ID_WIDTH'(AXI_ID);
    assign wr_idle_o  = ~awvalid_q & cmdq_empty & (outstanding_q == '0);
    assign wr_error_o = error_q;

`ifndef SYNTHESIS
    b_without_outstanding: assert property (
        @(posedge clk) disable iff (rst) bvalid_i |-> (outstanding_q != '0)
    );
`endif

endmodule

// File: tb/tb_dma_axi_wr_chan.sv
// Randomized bench for dma_axi_wr_chan against a transaction-count reference model.
module tb_dma_axi_wr_chan;
    import dma_utils_pkg::*;

    localparam int unsigned MaxOut = 4;
    localparam int unsigned AxiId  = 5;
    localparam int unsigned StrbW  = DMA_STRB_WIDTH;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      dma_abort_i;
    s_dma_axi_req_t            req;
    s_dma_axi_resp_t           resp;
    logic [DMA_DATA_WIDTH-1:0] fifo_rd_data_i;
    logic                      fifo_empty_i;
    logic                      fifo_rd_o;
    logic                      awvalid_o;
    logic                      awready_i;
    logic [DMA_ADDR_WIDTH-1:0] awaddr_o;
    logic [7:0]                awlen_o;
    logic [2:0]                awsize_o;
    axi_burst_t                awburst_o;
    logic [AXI_ID_WIDTH-1:0]   awid_o;
    logic                      wvalid_o;
    logic                      wready_i;
    logic [DMA_DATA_WIDTH-1:0] wdata_o;
    logic [StrbW-1:0]          wstrb_o;
    logic                      wlast_o;
    logic                      bvalid_i;
    logic                      bready_o;
    logic [1:0]                bresp_i;
    logic                      wr_idle_o;
    logic                      wr_error_o;

    always #5 clk = ~clk;

    dma_axi_wr_chan #(
        .MAX_OUTSTANDING (MaxOut),
        .AXI_ID          (AxiId)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dma_abort_i    (dma_abort_i),
        .dma_axi_req_i  (req),
        .dma_axi_resp_o (resp),
        .fifo_rd_data_i (fifo_rd_data_i),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_rd_o      (fifo_rd_o),
        .awvalid_o      (awvalid_o),
        .awready_i      (awready_i),
        .awaddr_o       (awaddr_o),
        .awlen_o        (awlen_o),
        .awsize_o       (awsize_o),
        .awburst_o      (awburst_o),
        .awid_o         (awid_o),
        .wvalid_o       (wvalid_o),
        .wready_i       (wready_i),
        .wdata_o        (wdata_o),
        .wstrb_o        (wstrb_o),
        .wlast_o        (wlast_o),
        .bvalid_i       (bvalid_i),
        .bready_o       (bready_o),
        .bresp_i        (bresp_i),
        .wr_idle_o      (wr_idle_o),
        .wr_error_o     (wr_error_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: counts of accepted bursts and of completed AW/W/B transactions.
    s_dma_axi_req_t            aw_exp_q[$];
    s_wr_cmd_t                 w_exp_q[$];
    logic [DMA_DATA_WIDTH-1:0] data_q[$];
    int                        accepted;
    int                        aw_done;
    int                        w_done;
    int                        b_done;
    int                        beat;
    logic                      err_exp;
    logic                      req_taken;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic chance(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    task automatic model_clear();
        aw_exp_q.delete();
        w_exp_q.delete();
        accepted  = 0;
        aw_done   = 0;
        w_done    = 0;
        b_done    = 0;
        beat      = 0;
        err_exp   = 1'b0;
        req_taken = 1'b1;
    endtask

    task automatic drive(input int p_valid, input int p_aw, input int p_w, input int p_b,
                         input int p_empty, input int p_berr, input logic abort);
        logic b_avail;
        dma_abort_i = abort;
        // A streamer holds its request until accepted.
        if (!req.valid || req_taken) begin
            req = '0;
            if (chance(p_valid)) begin
                req.valid = 1'b1;
                req.addr  = $urandom;
                req.alen  = chance(15) ? 8'd15 : 8'($urandom_range(0, 5));
                req.size  = 3'd2;
                req.strb  = StrbW'($urandom);
                req.mode  = chance(50) ? BURST_INCR : BURST_FIXED;
            end
        end
        req_taken = 1'b0;
        while (data_q.size() < 8) data_q.push_back($urandom);
        fifo_rd_data_i = data_q[0];
        fifo_empty_i   = chance(p_empty);
        awready_i      = chance(p_aw);
        wready_i       = chance(p_w);
        b_avail        = (b_done < aw_done) && (b_done < w_done);
        bvalid_i       = b_avail && chance(p_b);
        bresp_i        = (bvalid_i && chance(p_berr)) ? 2'b10 : AXI_OKAY;
    endtask

    task automatic sample();
        int   outst;
        int   cmdq_n;
        logic aw_pend;
        logic exp_ready;
        logic exp_wvalid;
        logic w_hs;
        outst      = accepted - b_done;
        cmdq_n     = accepted - w_done;
        aw_pend    = (accepted - aw_done) > 0;
        exp_ready  = req.valid && !dma_abort_i && (!aw_pend || awready_i) &&
                     (cmdq_n < int'(MaxOut)) && (outst < int'(MaxOut)) && !err_exp;
        exp_wvalid = (cmdq_n > 0) && !fifo_empty_i;
        w_hs       = exp_wvalid && wready_i;

        check_eq("ready", resp.ready, exp_ready);
        check_eq("awvalid", awvalid_o, aw_pend);
        if (aw_pend) begin
            check_eq("awaddr", awaddr_o, aw_exp_q[0].addr);
            check_eq("awlen", awlen_o, aw_exp_q[0].alen);
            check_eq("awsize", awsize_o, aw_exp_q[0].size);
            check_eq("awburst", awburst_o, aw_exp_q[0].mode);
            check_eq("awid", awid_o, AxiId);
        end
        check_eq("wvalid", wvalid_o, exp_wvalid);
        check_eq("fifo_rd", fifo_rd_o, w_hs);
        if (exp_wvalid) begin
            check_eq("wdata", wdata_o, data_q[0]);
            check_eq("wstrb", wstrb_o, w_exp_q[0].strb);
            check_eq("wlast", wlast_o, beat == int'(w_exp_q[0].alen));
        end
        check_eq("bready", bready_o, 1'b1);
        check_eq("wr_idle", wr_idle_o, accepted == b_done);
        check_eq("wr_error", wr_error_o, err_exp);

        if (aw_pend && awready_i) begin
            void'(aw_exp_q.pop_front());
            aw_done++;
        end
        if (w_hs) begin
            void'(data_q.pop_front());
            if (beat == int'(w_exp_q[0].alen)) begin
                beat = 0;
                void'(w_exp_q.pop_front());
                w_done++;
            end else begin
                beat++;
            end
        end
        if (bvalid_i) begin
            b_done++;
`ifdef DMA_WR_BRESP_CHK_EN
            if (bresp_i != AXI_OKAY) err_exp = 1'b1;
`endif
        end
        if (exp_ready) begin
            aw_exp_q.push_back(req);
            w_exp_q.push_back('{alen: req.alen, strb: req.strb});
            accepted++;
            req_taken = 1'b1;
        end
    endtask

    task automatic run(input int cycles, input int p_valid, input int p_aw, input int p_w,
                       input int p_b, input int p_empty, input int p_berr, input logic abort);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            drive(p_valid, p_aw, p_w, p_b, p_empty, p_berr, abort);
            #2;
            sample();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        req          = '0;
        dma_abort_i  = 1'b0;
        awready_i    = 1'b0;
        wready_i     = 1'b0;
        bvalid_i     = 1'b0;
        bresp_i      = AXI_OKAY;
        fifo_empty_i = 1'b0;
        if (data_q.size() == 0) data_q.push_back($urandom);
        fifo_rd_data_i = data_q[0];
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check_eq("rst_ready", resp.ready, 1'b0);
        check_eq("rst_awvalid", awvalid_o, 1'b0);
        check_eq("rst_wvalid", wvalid_o, 1'b0);
        check_eq("rst_fifo_rd", fifo_rd_o, 1'b0);
        check_eq("rst_wr_error", wr_error_o, 1'b0);
        check_eq("rst_wr_idle", wr_idle_o, 1'b1);
        check_eq("rst_bready", bready_o, 1'b1);
        model_clear();
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        req = '0;
        model_clear();
        do_reset();
        run(400, 70, 70, 70, 60, 0, 0, 1'b0);   // mixed traffic
        run(60, 100, 100, 100, 0, 0, 0, 1'b0);  // B withheld: outstanding limit
        run(300, 60, 80, 50, 60, 50, 0, 1'b0);  // W stalls and empty FIFO
        run(150, 90, 70, 70, 60, 10, 0, 1'b1);  // abort mid-traffic
        run(200, 70, 70, 70, 60, 10, 15, 1'b0); // error responses
        do_reset();
        run(300, 70, 70, 70, 60, 20, 0, 1'b0);
        guard = 0;
        while ((accepted != b_done) && (guard < 2000)) begin
            run(1, 0, 100, 100, 100, 0, 0, 1'b1);
            guard++;
        end
        @(negedge clk);
        #2;
        check_eq("final_idle", wr_idle_o, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
